axi_lite_cmd_master: RTL and testbench

- Single-outstanding AXI4-Lite master that turns simple register read/write commands into AXI-Lite channel traffic.
- Sits directly upstream of the AXI-Lite slave register blocks and drives their AW/W/B/AR/R channels.
- Returns one response per command, carrying read data and the response code.
- A cycle-count timeout guarantees a response even when the slave hangs.

---
 rtl/axi_lite_cmd_master.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back, with a cycle-count watchdog so a hung slave still completes.
// state | meaning
// IDLE  | ready to accept a command
// WRITE | AW and W in flight, each retired independently
// WRESP | waiting for the B handshake
// READ  | AR in flight
// RDATA | waiting for the R handshake
// RESP  | response held until the requester takes it
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_write,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    // Counter holds the number of busy cycles already elapsed, so the limit
    // is hit during the TIMEOUT_CYCLES-th busy cycle.
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
        TMO_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                   state, state_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
    logic                     tmo_hit, busy, do_timeout;

    logic                    cmd_ready_nxt, rsp_valid_nxt, rsp_write_nxt, rsp_timeout_nxt;
    logic [1:0]              rsp_resp_nxt;
    logic [DATA_WIDTH-1:0]   rsp_data_nxt, wdata_nxt;
    logic                    awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
    logic [STROBE_WIDTH-1:0] wstrb_nxt;

    assign busy    = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RDATA);
    assign tmo_hit = TMO_EN && (tmo_cnt >= TMO_LAST);

    always_comb begin
        state_nxt       = state;
        tmo_cnt_nxt     = tmo_cnt;
        do_timeout      = 1'b0;
        cmd_ready_nxt   = o_cmd_ready;
        rsp_valid_nxt   = o_rsp_valid;
        rsp_write_nxt   = o_rsp_write;
        rsp_resp_nxt    = o_rsp_resp;
        rsp_timeout_nxt = o_rsp_timeout;
        rsp_data_nxt    = o_rsp_data;
        awvalid_nxt     = o_awvalid;
        awaddr_nxt      = o_awaddr;
        wvalid_nxt      = o_wvalid;
        wstrb_nxt       = o_wstrb;
        wdata_nxt       = o_wdata;
        bready_nxt      = o_bready;
        arvalid_nxt     = o_arvalid;
        araddr_nxt      = o_araddr;
        rready_nxt      = o_rready;

        if (busy && (tmo_cnt != '1)) begin
            tmo_cnt_nxt = tmo_cnt + TIMEOUT_WIDTH'(1);
        end

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (i_cmd_valid && o_cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    tmo_cnt_nxt   = '0;
                    rsp_write_nxt = i_cmd_write;
                    if (i_cmd_write) begin
                        awaddr_nxt  = i_cmd_addr;
                        wdata_nxt   = i_cmd_data;
                        wstrb_nxt   = i_cmd_strb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WRITE;
                    end else begin
                        araddr_nxt  = i_cmd_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = READ;
                    end
                end
            end
            WRITE: begin
                awvalid_nxt = o_awvalid && !i_awready;
                wvalid_nxt  = o_wvalid && !i_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WRESP;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            WRESP: begin
                if (i_bvalid && o_bready) begin
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = i_bresp;
                    rsp_timeout_nxt = 1'b0;
                    rsp_data_nxt    = '0;
                    state_nxt       = RESP;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            READ: begin
                if (i_arready && o_arvalid) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RDATA;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            RDATA: begin
                if (i_rvalid && o_rready) begin
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = i_rresp;
                    rsp_timeout_nxt = 1'b0;
                    rsp_data_nxt    = i_rdata;
                    state_nxt       = RESP;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_timeout) begin
            awvalid_nxt     = 1'b0;
            wvalid_nxt      = 1'b0;
            bready_nxt      = 1'b0;
            arvalid_nxt     = 1'b0;
            rready_nxt      = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_timeout_nxt = 1'b1;
            rsp_resp_nxt    = 2'b11;
            rsp_data_nxt    = '0;
            state_nxt       = RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_cmd_ready   <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_write   <= 1'b0;
            o_rsp_resp    <= 2'b00;
            o_rsp_timeout <= 1'b0;
            o_rsp_data    <= '0;
            o_awvalid     <= 1'b0;
            o_awaddr      <= '0;
            o_wvalid      <= 1'b0;
            o_wstrb       <= '0;
            o_wdata       <= '0;
            o_bready      <= 1'b0;
            o_arvalid     <= 1'b0;
            o_araddr      <= '0;
            o_rready      <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            o_cmd_ready   <= cmd_ready_nxt;
            o_rsp_valid   <= rsp_valid_nxt;
            o_rsp_write   <= rsp_write_nxt;
            o_rsp_resp    <= rsp_resp_nxt;
            o_rsp_timeout <= rsp_timeout_nxt;
            o_rsp_data    <= rsp_data_nxt;
            o_awvalid     <= awvalid_nxt;
            o_awaddr      <= awaddr_nxt;
            o_wvalid      <= wvalid_nxt;
            o_wstrb       <= wstrb_nxt;
            o_wdata       <= wdata_nxt;
            o_bready      <= bready_nxt;
            o_arvalid     <= arvalid_nxt;
            o_araddr      <= araddr_nxt;
            o_rready      <= rready_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: stimulus pushes expected responses,
// a monitor pops and compares them at each response handshake.
module tb_axi_lite_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;
    localparam int TW  = 16;

    if (TMO > (2 ** TW) - 1) begin : g_bad_timeout
        initial $fatal(1, "illegal TIMEOUT_CYCLES for TIMEOUT_WIDTH");
    end

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_strb;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_timeout;
    logic [1:0]    o_rsp_resp;
    logic [DW-1:0] o_rsp_data;
    logic          o_awvalid, i_awready, o_wvalid, i_wready;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [SW-1:0] o_wstrb;
    logic [DW-1:0] o_wdata, i_rdata;
    logic          i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
    logic [1:0]    i_bresp, i_rresp;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW),
        .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout), .o_rsp_data(o_rsp_data),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wstrb(o_wstrb), .o_wdata(o_wdata),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          w;
        logic [1:0]    r;
        logic          t;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   b_hs  = 0;
    int   bh0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (i_bvalid && o_bready) b_hs++;
        if (o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail_bound("unexpected_rsp");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_write",   64'(o_rsp_write),   64'(mon_e.w));
                check("rsp_resp",    64'(o_rsp_resp),    64'(mon_e.r));
                check("rsp_timeout", 64'(o_rsp_timeout), 64'(mon_e.t));
                check("rsp_data",    64'(o_rsp_data),    64'(mon_e.d));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Waits for o_cmd_ready, presents the command for one edge; returns in cycle 1.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        int n = 0;
        @(negedge clk);
        while (!o_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_bound("cmd_ready_wait");
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = a;
        i_cmd_data  = d;
        i_cmd_strb  = s;
        next();
        i_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            next();
            n++;
        end
        if (n >= 100) fail_bound("drain_wait");
    endtask

    task automatic push(input logic w, input logic [1:0] r, input logic t, input logic [DW-1:0] d);
        exp_t e;
        e.w = w; e.r = r; e.t = t; e.d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0;
        i_rsp_ready = 1; i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = '0;

        repeat (2) next();
        smp();
        check("rst_cmd_ready", 64'(o_cmd_ready), 64'd0);
        check("rst_awvalid",   64'(o_awvalid),   64'd0);
        check("rst_arvalid",   64'(o_arvalid),   64'd0);
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rst_awaddr",    64'(o_awaddr),    64'd0);
        rst = 1'b1;
        next(); smp();
        check("post_rst_cmd_ready", 64'(o_cmd_ready), 64'd1);

        // zero-wait write
        i_awready = 1; i_wready = 1; i_bvalid = 1; i_bresp = 2'b00;
        push(1'b1, 2'b00, 1'b0, 32'h0);
        issue(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
        smp();
        check("w1_c1_awvalid", 64'(o_awvalid), 64'd1);
        check("w1_c1_wvalid",  64'(o_wvalid),  64'd1);
        check("w1_c1_awaddr",  64'(o_awaddr),  64'h04);
        check("w1_c1_wdata",   64'(o_wdata),   64'hDEADBEEF);
        check("w1_c1_wstrb",   64'(o_wstrb),   64'hF);
        check("w1_c1_cmd_ready", 64'(o_cmd_ready), 64'd0);
        next(); smp();
        check("w1_c2_awvalid", 64'(o_awvalid), 64'd0);
        check("w1_c2_wvalid",  64'(o_wvalid),  64'd0);
        check("w1_c2_bready",  64'(o_bready),  64'd1);
        check("w1_c2_rsp_valid", 64'(o_rsp_valid), 64'd0);
        next(); smp();
        check("w1_c3_rsp_valid", 64'(o_rsp_valid), 64'd1);
        check("w1_c3_bready",    64'(o_bready),    64'd0);
        next(); smp();
        check("w1_c4_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("w1_c4_cmd_ready", 64'(o_cmd_ready), 64'd1);

        // AWREADY three cycles behind WREADY
        i_awready = 0; i_wready = 1; i_bvalid = 1; i_bresp = 2'b01;
        push(1'b1, 2'b01, 1'b0, 32'h0);
        bh0 = b_hs;
        issue(1'b1, 32'h14, 32'h01020304, 4'hC);
        smp();
        check("w2_c1_awvalid", 64'(o_awvalid), 64'd1);
        check("w2_c1_wvalid",  64'(o_wvalid),  64'd1);
        next(); smp();
        check("w2_c2_wvalid",  64'(o_wvalid),  64'd0);
        check("w2_c2_awvalid", 64'(o_awvalid), 64'd1);
        next(); smp();
        check("w2_c3_awvalid", 64'(o_awvalid), 64'd1);
        check("w2_c3_awaddr",  64'(o_awaddr),  64'h14);
        next(); i_awready = 1; smp();
        check("w2_c4_awvalid", 64'(o_awvalid), 64'd1);
        check("w2_c4_bready",  64'(o_bready),  64'd0);
        next(); i_awready = 0; smp();
        check("w2_c5_awvalid", 64'(o_awvalid), 64'd0);
        check("w2_c5_bready",  64'(o_bready),  64'd1);
        next(); smp();
        check("w2_c6_rsp_valid", 64'(o_rsp_valid), 64'd1);
        next(); smp();
        check("w2_b_handshakes", 64'(b_hs - bh0), 64'd1);
        drain();

        // read with two R wait cycles
        i_bvalid = 0; i_bresp = 2'b00; i_arready = 1; i_rvalid = 0;
        i_rresp = 2'b10; i_rdata = 32'h12345678;
        push(1'b0, 2'b10, 1'b0, 32'h12345678);
        issue(1'b0, 32'h08, 32'h0, 4'h0);
        smp();
        check("r1_c1_arvalid", 64'(o_arvalid), 64'd1);
        check("r1_c1_araddr",  64'(o_araddr),  64'h08);
        next(); smp();
        check("r1_c2_arvalid", 64'(o_arvalid), 64'd0);
        check("r1_c2_rready",  64'(o_rready),  64'd1);
        next(); smp();
        check("r1_c3_rready",    64'(o_rready),    64'd1);
        check("r1_c3_rsp_valid", 64'(o_rsp_valid), 64'd0);
        next(); i_rvalid = 1; smp();
        check("r1_c4_rready", 64'(o_rready), 64'd1);
        next(); i_rvalid = 0; smp();
        check("r1_c5_rsp_valid", 64'(o_rsp_valid), 64'd1);
        check("r1_c5_rready",    64'(o_rready),    64'd0);
        drain();

        // response back-pressure with a second command already waiting
        i_rsp_ready = 0; i_arready = 1; i_rvalid = 1; i_rresp = 2'b00; i_rdata = 32'hA5A50001;
        i_awready = 1; i_wready = 1; i_bvalid = 1; i_bresp = 2'b00;
        push(1'b0, 2'b00, 1'b0, 32'hA5A50001);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        push(1'b1, 2'b00, 1'b0, 32'h0);
        i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 32'h20;
        i_cmd_data = 32'h0BADF00D; i_cmd_strb = 4'h3;
        smp();
        check("bp_c1_cmd_ready", 64'(o_cmd_ready), 64'd0);
        next(); smp();
        check("bp_c2_cmd_ready", 64'(o_cmd_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            next(); smp();
            check("bp_hold_rsp_valid", 64'(o_rsp_valid), 64'd1);
            check("bp_hold_rsp_data",  64'(o_rsp_data),  64'hA5A50001);
            check("bp_hold_rsp_write", 64'(o_rsp_write), 64'd0);
            check("bp_hold_cmd_ready", 64'(o_cmd_ready), 64'd0);
            check("bp_hold_awvalid",   64'(o_awvalid),   64'd0);
        end
        next(); i_rsp_ready = 1; smp();
        check("bp_c8_rsp_valid", 64'(o_rsp_valid), 64'd1);
        next(); smp();
        check("bp_c9_cmd_ready", 64'(o_cmd_ready), 64'd1);
        check("bp_c9_rsp_valid", 64'(o_rsp_valid), 64'd0);
        next(); i_cmd_valid = 0; smp();
        check("bp_c10_awvalid",   64'(o_awvalid),   64'd1);
        check("bp_c10_awaddr",    64'(o_awaddr),    64'h20);
        check("bp_c10_wdata",     64'(o_wdata),     64'h0BADF00D);
        check("bp_c10_cmd_ready", 64'(o_cmd_ready), 64'd0);
        drain();

        // ARREADY never comes: forced completion after TMO busy cycles
        i_bvalid = 0; i_arready = 0; i_rvalid = 0; i_rdata = 32'hFFFFFFFF;
        push(1'b0, 2'b11, 1'b1, 32'h0);
        issue(1'b0, 32'h0C, 32'h0, 4'h0);
        smp();
        check("to_c1_arvalid", 64'(o_arvalid), 64'd1);
        repeat (TMO - 1) next();
        smp();
        check("to_c16_arvalid",   64'(o_arvalid),   64'd1);
        check("to_c16_rsp_valid", 64'(o_rsp_valid), 64'd0);
        next(); smp();
        check("to_c17_arvalid",     64'(o_arvalid),     64'd0);
        check("to_c17_rready",      64'(o_rready),      64'd0);
        check("to_c17_rsp_valid",   64'(o_rsp_valid),   64'd1);
        check("to_c17_rsp_timeout", 64'(o_rsp_timeout), 64'd1);
        drain();

        // handshakes landing on the timeout edge complete normally
        i_rdata = 32'h5555AAAA; i_rresp = 2'b00;
        push(1'b0, 2'b00, 1'b0, 32'h5555AAAA);
        issue(1'b0, 32'h18, 32'h0, 4'h0);
        smp();
        repeat (TMO - 1) next();
        i_arready = 1; smp();
        check("tw_c16_arvalid", 64'(o_arvalid), 64'd1);
        next(); i_arready = 0; i_rvalid = 1; smp();
        check("tw_c17_rready",    64'(o_rready),    64'd1);
        check("tw_c17_arvalid",   64'(o_arvalid),   64'd0);
        check("tw_c17_rsp_valid", 64'(o_rsp_valid), 64'd0);
        next(); i_rvalid = 0; smp();
        check("tw_c18_rsp_valid",   64'(o_rsp_valid),   64'd1);
        check("tw_c18_rsp_timeout", 64'(o_rsp_timeout), 64'd0);
        drain();

        // reset while waiting for B
        i_awready = 1; i_wready = 1; i_bvalid = 0;
        issue(1'b1, 32'h1C, 32'h00000077, 4'hF);
        smp();
        check("rs_c1_awvalid", 64'(o_awvalid), 64'd1);
        next(); smp();
        check("rs_c2_bready", 64'(o_bready), 64'd1);
        rst = 1'b0;
        next(); smp();
        check("rs_c3_awvalid",   64'(o_awvalid),   64'd0);
        check("rs_c3_wvalid",    64'(o_wvalid),    64'd0);
        check("rs_c3_bready",    64'(o_bready),    64'd0);
        check("rs_c3_arvalid",   64'(o_arvalid),   64'd0);
        check("rs_c3_rready",    64'(o_rready),    64'd0);
        check("rs_c3_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rs_c3_cmd_ready", 64'(o_cmd_ready), 64'd0);
        check("rs_c3_awaddr",    64'(o_awaddr),    64'd0);
        rst = 1'b1;
        i_bvalid = 1;
        next(); smp();
        check("rs_c4_cmd_ready", 64'(o_cmd_ready), 64'd1);
        check("rs_c4_rsp_valid", 64'(o_rsp_valid), 64'd0);
        i_arready = 1; i_rvalid = 1; i_rresp = 2'b00; i_rdata = 32'hCAFE0006;
        push(1'b0, 2'b00, 1'b0, 32'hCAFE0006);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        drain();
        repeat (3) next();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
